// File: rtl/udp_frame_pack_mux_if.sv
// Source-side and transmit-side signal bundle for udp_frame_pack_mux.
// master: the mux itself (drives src_ready and the tx word stream).
// slave:  the surrounding logic (capture sources and the UDP TX engine).
interface udp_frame_pack_mux_if #(
  parameter int NUM_SRC   = 2,
  parameter int OUT_BYTES = 3,
  parameter int LEN_W     = 16
);
  localparam int DW = 8 * OUT_BYTES;

  logic [2:0]            sel;
  logic [NUM_SRC*DW-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_last;
  logic [NUM_SRC-1:0]    src_ready;
  logic [DW-1:0]         tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;
  logic [LEN_W-1:0]      tx_length;
  logic                  tx_done;
  logic                  tx_overrun;

  modport master (
    input  sel, src_data, src_valid, src_last, tx_ready,
    output src_ready, tx_data, tx_valid, tx_last, tx_length, tx_done, tx_overrun
  );

  modport slave (
    output sel, src_data, src_valid, src_last, tx_ready,
    input  src_ready, tx_data, tx_valid, tx_last, tx_length, tx_done, tx_overrun
  );
endinterface

// File: rtl/udp_frame_pack_mux.sv
// N-source front end for the UDP transmit path. One source is chosen per
// frame; byte-wide sources are packed MSB-first into OUT_BYTES-wide words,
// word-wide sources pass straight through. Output is a registered
// ready/valid word stream with frame-last, a word count and a done pulse.
module udp_frame_pack_mux #(
  parameter int                 NUM_SRC       = 2,
  parameter int                 OUT_BYTES     = 3,
  parameter int                 LEN_W         = 16,
  parameter logic [NUM_SRC-1:0] SRC_BYTE_MASK = 2'b01,
  parameter logic [NUM_SRC-1:0] SRC_EDGE_MASK = 2'b10
) (
  input logic                 clk,
  input logic                 reset_n,
  udp_frame_pack_mux_if.master bus
);
  localparam int              DW       = 8 * OUT_BYTES;
  localparam logic [3:0]      NSRC     = 4'(NUM_SRC);
  localparam logic [2:0]      CNT_FULL = 3'(OUT_BYTES - 1);
  localparam logic [LEN_W-1:0] WCNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         act_q, act_d;
  logic [NUM_SRC-1:0] prev_valid_q;
  logic [DW-1:0]      pack_q, pack_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic               last_seen_q, last_seen_d;
  logic [DW-1:0]      tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic               overrun_q, overrun_d;

  logic [DW-1:0]      s_data;
  logic               s_valid, s_last, s_prev, s_byte, s_edge;
  logic               out_free, beat_ok, take, emit, ovr_evt;
  logic [5:0]         sh;
  logic [DW-1:0]      byte_word, word;

  // Route the active source's signals onto a common set of wires.
  always_comb begin
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_prev  = 1'b0;
    s_byte  = 1'b0;
    s_edge  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (act_q == 3'(i)) begin
        s_data  = bus.src_data[i*DW +: DW];
        s_valid = bus.src_valid[i];
        s_last  = bus.src_last[i];
        s_prev  = prev_valid_q[i];
        s_byte  = SRC_BYTE_MASK[i];
        s_edge  = SRC_EDGE_MASK[i];
      end
    end
  end

  // Beat acceptance, packing arithmetic and the overrun event.
  // last_seen_q blocks beats of the next frame from slipping in while the
  // final word of this frame still waits downstream.
  always_comb begin
    out_free  = !tx_valid_q || bus.tx_ready;
    beat_ok   = s_edge ? (s_valid && !s_prev) : s_valid;
    take      = (state_q == S_RUN) && !last_seen_q && out_free && beat_ok;
    ovr_evt   = (state_q == S_RUN) && !last_seen_q && s_edge && s_valid && !s_prev && !out_free;
    sh        = 6'(DW - 8) - {bcnt_q, 3'b000};
    byte_word = pack_q | (DW'(s_data[7:0]) << sh);
    word      = s_byte ? byte_word : s_data;
    emit      = take && (!s_byte || s_last || (bcnt_q == CNT_FULL));
  end

  // Per-source ready plus frame-complete outputs.
  always_comb begin
    bus.src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = (state_q == S_RUN) && (act_q == 3'(i)) && !last_seen_q && out_free;
    end
    bus.tx_data    = tx_data_q;
    bus.tx_valid   = tx_valid_q;
    bus.tx_last    = tx_last_q;
    bus.tx_overrun = overrun_q;
    bus.tx_done    = (state_q == S_DONE);
    bus.tx_length  = (state_q == S_DONE) ? wcnt_q : '0;
  end

  // Next-state logic for the frame FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pack_d      = pack_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    last_seen_d = last_seen_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    tx_valid_d  = tx_valid_q && !bus.tx_ready;
    overrun_d   = overrun_q || ovr_evt;
    case (state_q)
      S_IDLE: begin
        if ({1'b0, bus.sel} < NSRC) begin
          act_d   = bus.sel;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (take && !emit) begin
          pack_d = byte_word;
          bcnt_d = bcnt_q + 3'd1;
        end
        if (emit) begin
          tx_data_d  = word;
          tx_valid_d = 1'b1;
          tx_last_d  = s_last;
          pack_d     = '0;
          bcnt_d     = '0;
          if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + LEN_W'(1);
          if (s_last) last_seen_d = 1'b1;
        end
        if (tx_valid_q && bus.tx_ready && tx_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        wcnt_d      = '0;
        last_seen_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers; a reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q        <= '0;
      prev_valid_q <= '0;
      pack_q       <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      last_seen_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      act_q        <= act_d;
      prev_valid_q <= bus.src_valid;
      pack_q       <= pack_d;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      last_seen_q  <= last_seen_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule
